// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one handshaked, single-ported memory between the fetch (I)
// and data (D) ports. One transaction in flight; data wins unless fetch has
// been passed over MAX_D_STREAK times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  d_owner_q, d_owner_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                  grant_d;
  logic                  resp;

  // Data wins unless a pending fetch has already been passed over MAX_D_STREAK times.
  assign grant_d = d_req && (!i_req || (streak_q < SW'(MAX_D_STREAK)));

  // State, streak counter, owner and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      d_owner_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      d_owner_q   <= d_owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold fields through ISSUE, await response in WAIT.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    d_owner_d   = d_owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          d_owner_d   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          if (!i_req) begin
            streak_d = '0;
          end else if (streak_q < SW'(MAX_D_STREAK)) begin
            streak_d = streak_q + 1'b1;
          end
          state_d = S_ISSUE;
        end else if (i_req) begin
          d_owner_d   = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          streak_d    = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp      = (state_q == S_WAIT) && mem_rvalid;
  assign i_rvalid  = resp && !d_owner_q;
  assign d_rvalid  = resp && d_owner_q;
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !mem_we_q) ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order and reset mid-transaction.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mem_data;
    int unsigned delay;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just before the grant edge with requests already driven.
  // Returns the owner, the returned data, and the ISSUE-cycle memory fields.
  task automatic serve(input logic [31:0] data, input int unsigned delay,
                       output logic was_d, output logic [31:0] got,
                       output logic s_we, output logic [31:0] s_addr,
                       output logic [31:0] s_wdata, output logic [3:0] s_wstrb);
    @(negedge clk);
    chk("issue_mem_req", mem_req, 1);
    chk("issue_busy", busy, 1);
    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
    for (int k = 0; k < int'(delay); k++) begin
      mem_ready = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_0000;
      #1;
      chk("issue_no_rvalid", {i_rvalid, d_rvalid}, 0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("stall_mem_req", mem_req, 1);
      chk("stall_addr", mem_addr, s_addr);
      chk("stall_we_wstrb_wdata", {mem_we, mem_wstrb, mem_wdata[26:0]},
          {s_we, s_wstrb, s_wdata[26:0]});
    end
    mem_rvalid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("wait_mem_req_low", mem_req, 0);
    chk("wait_no_rvalid", {i_rvalid, d_rvalid}, 0);
    mem_rvalid = 1'b1;
    mem_rdata = data;
    #1;
    chk("one_rvalid", i_rvalid ^ d_rvalid, 1);
    was_d = d_rvalid;
    got = d_rvalid ? d_rdata : i_rdata;
    chk("other_rdata_zero", d_rvalid ? i_rdata : d_rdata, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_no_rvalid", {i_rvalid, d_rvalid}, 0);
  endtask

  logic        was_d;
  logic [31:0] got;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [5:0]  order;
  logic [5:0]  exp_order;

  initial begin
    // is_d we addr wdata wstrb mem_data delay | exp_we exp_addr exp_wstrb exp_rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, 32'h0050_0093, 0,
                1'b0, 32'h0000_0100, 4'h0, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 0,
                1'b1, 32'h0000_2000, 4'h3, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 3,
                1'b0, 32'h0000_3004, 4'h0, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 32'h0000_0013, 1,
                1'b0, 32'h0000_0104, 4'h0, 32'h0000_0013};

    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_regs", {mem_req, mem_we, mem_wstrb}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    // A response while IDLE must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_rvalid_ignored", {i_rvalid, d_rvalid}, 0);
    chk("idle_rdata_zero", i_rdata | d_rdata, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      i_req = !vecs[v].is_d;
      d_req = vecs[v].is_d;
      i_addr = vecs[v].addr;
      d_addr = vecs[v].is_d ? vecs[v].addr : 32'h0000_0FF0;
      d_we = vecs[v].we; d_wdata = vecs[v].wdata; d_wstrb = vecs[v].wstrb;
      serve(vecs[v].mem_data, vecs[v].delay, was_d, got, s_we, s_addr, s_wdata, s_wstrb);
      chk("vec_owner", was_d, vecs[v].is_d);
      chk("vec_rdata", got, vecs[v].exp_rdata);
      chk("vec_mem_we", s_we, vecs[v].exp_we);
      chk("vec_mem_addr", s_addr, vecs[v].exp_addr);
      chk("vec_mem_wstrb", s_wstrb, vecs[v].exp_wstrb);
      if (vecs[v].is_d) chk("vec_mem_wdata", s_wdata, vecs[v].wdata);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
    end

    // Simultaneous requests: D first, then I once D drops.
    d_we = 1'b0; d_wstrb = '0;
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_addr = 32'h0000_0040;
    serve(32'hA0A0_A0A0, 0, was_d, got, s_we, s_addr, s_wdata, s_wstrb);
    chk("both_first_is_d", was_d, 1);
    chk("both_first_addr", s_addr, 32'h0000_0040);
    d_req = 1'b0;
    serve(32'hB0B0_B0B0, 0, was_d, got, s_we, s_addr, s_wdata, s_wstrb);
    chk("both_second_is_i", was_d, 0);
    chk("both_second_addr", s_addr, 32'h0000_0200);
    chk("both_second_rdata", got, 32'hB0B0_B0B0);

    // Both held for six transactions: starvation guard gives D,D,D,D,I,D.
    d_req = 1'b1; d_addr = 32'h0000_0044;
    exp_order = 6'b101111;
    for (int t = 0; t < 6; t++) begin
      serve(32'h0000_0100 + 32'(t), 0, was_d, got, s_we, s_addr, s_wdata, s_wstrb);
      order[t] = was_d;
    end
    chk("streak_order", {26'd0, order}, {26'd0, exp_order});
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Reset during WAIT, then a late response.
    d_req = 1'b1; d_addr = 32'h0000_5000;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    chk("late_rvalid_ignored", {i_rvalid, d_rvalid}, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mem_req", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0300;
    serve(32'h0000_0513, 0, was_d, got, s_we, s_addr, s_wdata, s_wstrb);
    chk("post_rst_owner", was_d, 0);
    chk("post_rst_addr", s_addr, 32'h0000_0300);
    chk("post_rst_rdata", got, 32'h0000_0513);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
